// File: rtl/sub_nbit_serial.sv
// Bit-serial unsigned subtractor: one full-subtractor cell computes A - B - bor, LSB first,
// with valid/ready handshakes on both the operand and the result side.
module sub_nbit_serial #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_valid,
    output logic                  o_ready,
    input  logic [DATA_WIDTH-1:0] i_num_a,
    input  logic [DATA_WIDTH-1:0] i_num_b,
    input  logic                  i_bor,
    output logic                  o_valid,
    input  logic                  i_ready,
    output logic [DATA_WIDTH-1:0] o_res,
    output logic                  o_bor,
    output logic                  o_busy
);

    localparam int CW = $clog2(DATA_WIDTH);
    localparam logic [CW-1:0] CNT_LAST = CW'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_DONE
    } state_t;

    state_t                state_q;
    logic [DATA_WIDTH-1:0] sh_a_q;
    logic [DATA_WIDTH-1:0] sh_b_q;
    logic [DATA_WIDTH-1:0] res_q;
    logic                  bor_q;
    logic [CW-1:0]         cnt_q;
    logic                  ready_q;
    logic                  valid_q;
    logic                  busy_q;
    logic [DATA_WIDTH-1:0] out_res_q;
    logic                  out_bor_q;

    logic bit_a;
    logic bit_b;
    logic diff_d;
    logic bor_d;

    // Single full-subtractor cell working on the current LSBs.
    assign bit_a  = sh_a_q[0];
    assign bit_b  = sh_b_q[0];
    assign diff_d = bit_a ^ bit_b ^ bor_q;
    assign bor_d  = (~bit_a & bit_b) | (~(bit_a ^ bit_b) & bor_q);

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q   <= S_IDLE;
            sh_a_q    <= '0;
            sh_b_q    <= '0;
            res_q     <= '0;
            bor_q     <= 1'b0;
            cnt_q     <= '0;
            ready_q   <= 1'b1;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
            out_res_q <= '0;
            out_bor_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (i_valid && ready_q) begin
                        sh_a_q  <= i_num_a;
                        sh_b_q  <= i_num_b;
                        bor_q   <= i_bor;
                        res_q   <= '0;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        busy_q  <= 1'b1;
                        state_q <= S_CALC;
                    end
                end
                S_CALC: begin
                    sh_a_q <= sh_a_q >> 1;
                    sh_b_q <= sh_b_q >> 1;
                    res_q  <= {diff_d, res_q[DATA_WIDTH-1:1]};
                    bor_q  <= bor_d;
                    if (cnt_q == CNT_LAST) begin
                        // Output registers are loaded only here so they keep the last result otherwise.
                        out_res_q <= {diff_d, res_q[DATA_WIDTH-1:1]};
                        out_bor_q <= bor_d;
                        busy_q    <= 1'b0;
                        state_q   <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    if (valid_q && i_ready) begin
                        valid_q <= 1'b0;
                        ready_q <= 1'b1;
                        state_q <= S_IDLE;
                    end else begin
                        valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    ready_q <= 1'b1;
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign o_ready = ready_q;
    assign o_valid = valid_q;
    assign o_busy  = busy_q;
    assign o_res   = out_res_q;
    assign o_bor   = out_bor_q;

endmodule

// File: tb/tb_sub_nbit_serial.sv
// Self-checking bench for sub_nbit_serial (DATA_WIDTH=8): vector table, corner sequences
// and randomised ops against a 9-bit arithmetic reference.
module tb_sub_nbit_serial;

    localparam int N   = 8;
    localparam int LAT = N + 1;

    logic         i_clk = 1'b0;
    logic         i_rst;
    logic         i_valid;
    logic         o_ready;
    logic [N-1:0] i_num_a;
    logic [N-1:0] i_num_b;
    logic         i_bor;
    logic         o_valid;
    logic         i_ready;
    logic [N-1:0] o_res;
    logic         o_bor;
    logic         o_busy;

    int checks = 0;
    int errors = 0;

    sub_nbit_serial #(.DATA_WIDTH(N)) dut (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_valid (i_valid),
        .o_ready (o_ready),
        .i_num_a (i_num_a),
        .i_num_b (i_num_b),
        .i_bor   (i_bor),
        .o_valid (o_valid),
        .i_ready (i_ready),
        .o_res   (o_res),
        .o_bor   (o_bor),
        .o_busy  (o_busy)
    );

    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic         bor;
        logic [N-1:0] exp_res;
        logic         exp_bor;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    task automatic model(input logic [N-1:0] a, input logic [N-1:0] b, input logic bo,
                         output logic [N-1:0] r, output logic rb);
        logic [N:0] full;
        full = {1'b0, a} - {1'b0, b} - {{N{1'b0}}, bo};
        r  = full[N-1:0];
        rb = full[N];
    endtask

    // Runs one op; hold = cycles of i_ready=0 after o_valid appears, during which outputs must stay put.
    task automatic do_op(input logic [N-1:0] a, input logic [N-1:0] b, input logic bo,
                         input int hold, output logic [N-1:0] r, output logic rb, output int lat);
        int n;
        n = 0;
        while (!o_ready && n < 50) begin
            tick();
            n++;
        end
        if (!o_ready) begin
            errors++;
            $display("FAIL ready_timeout got %0d expected 1", o_ready);
        end
        i_num_a = a;
        i_num_b = b;
        i_bor   = bo;
        i_valid = 1'b1;
        i_ready = (hold == 0);
        tick();
        i_valid = 1'b0;
        i_num_a = N'($urandom);
        i_num_b = N'($urandom);
        i_bor   = 1'($urandom);
        lat = 0;
        while (!o_valid && lat < 50) begin
            tick();
            lat++;
        end
        r  = o_res;
        rb = o_bor;
        for (int i = 0; i < hold; i++) begin
            tick();
            check("hold_valid", {31'd0, o_valid}, 32'd1);
            check("hold_res", {23'd0, o_bor, o_res}, {23'd0, rb, r});
        end
        i_ready = 1'b1;
        tick();
        i_ready = 1'b0;
    endtask

    vec_t         vecs[6];
    logic [N-1:0] r, er;
    logic         rb, erb;
    int           lat;

    initial begin
        vecs[0] = '{8'h5A, 8'h3C, 1'b0, 8'h1E, 1'b0};
        vecs[1] = '{8'h00, 8'h01, 1'b0, 8'hFF, 1'b1};
        vecs[2] = '{8'h80, 8'h7F, 1'b1, 8'h00, 1'b0};
        vecs[3] = '{8'h10, 8'h01, 1'b0, 8'h0F, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 1'b1, 8'hFF, 1'b1};
        vecs[5] = '{8'hFF, 8'h00, 1'b0, 8'hFF, 1'b0};

        i_rst   = 1'b1;
        i_valid = 1'b0;
        i_ready = 1'b0;
        i_num_a = '0;
        i_num_b = '0;
        i_bor   = 1'b0;
        tick();
        tick();
        check("rst_ready", {31'd0, o_ready}, 32'd1);
        check("rst_valid", {31'd0, o_valid}, 32'd0);
        check("rst_busy",  {31'd0, o_busy},  32'd0);
        check("rst_res",   {24'd0, o_res},   32'd0);
        check("rst_bor",   {31'd0, o_bor},   32'd0);
        i_rst = 1'b0;
        tick();

        // Table-driven vectors with immediate hand-off.
        foreach (vecs[k]) begin
            do_op(vecs[k].a, vecs[k].b, vecs[k].bor, 0, r, rb, lat);
            check("vec_latency", lat, LAT);
            check("vec_res", {24'd0, r}, {24'd0, vecs[k].exp_res});
            check("vec_bor", {31'd0, rb}, {31'd0, vecs[k].exp_bor});
            check("vec_valid_pulse", {31'd0, o_valid}, 32'd0);
            check("vec_ready_back", {31'd0, o_ready}, 32'd1);
        end

        // Backpressure: result held for 10 cycles with i_ready low.
        do_op(8'hFF, 8'hFF, 1'b1, 10, r, rb, lat);
        check("bp_latency", lat, LAT);
        check("bp_res", {24'd0, r}, 32'hFF);
        check("bp_bor", {31'd0, rb}, 32'd1);
        check("bp_valid_after", {31'd0, o_valid}, 32'd0);
        check("bp_ready_after", {31'd0, o_ready}, 32'd1);

        // New operands pulsed mid-CALC must be ignored.
        i_num_a = 8'h5A; i_num_b = 8'h3C; i_bor = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        check("calc_busy", {31'd0, o_busy}, 32'd1);
        check("calc_ready", {31'd0, o_ready}, 32'd0);
        i_num_a = 8'h01; i_num_b = 8'hF0; i_bor = 1'b1; i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        lat = 3;
        while (!o_valid && lat < 50) begin
            tick();
            lat++;
        end
        check("ignore_latency", lat, LAT);
        check("ignore_res", {24'd0, o_res}, 32'h1E);
        check("ignore_bor", {31'd0, o_bor}, 32'd0);
        tick();
        i_ready = 1'b0;
        check("ignore_ready_back", {31'd0, o_ready}, 32'd1);

        // Reset during the 3rd CALC cycle drops the op.
        i_num_a = 8'hFF; i_num_b = 8'h01; i_bor = 1'b0; i_valid = 1'b1; i_ready = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        check("midrst_ready", {31'd0, o_ready}, 32'd1);
        check("midrst_valid", {31'd0, o_valid}, 32'd0);
        check("midrst_busy",  {31'd0, o_busy},  32'd0);
        check("midrst_res",   {24'd0, o_res},   32'd0);
        check("midrst_bor",   {31'd0, o_bor},   32'd0);
        for (int i = 0; i < 12; i++) begin
            tick();
            check("midrst_no_valid", {31'd0, o_valid}, 32'd0);
        end
        i_ready = 1'b0;
        do_op(8'h10, 8'h01, 1'b0, 0, r, rb, lat);
        check("post_rst_latency", lat, LAT);
        check("post_rst_res", {24'd0, r}, 32'h0F);
        check("post_rst_bor", {31'd0, rb}, 32'd0);

        // Randomised ops with idle gaps and random backpressure.
        for (int k = 0; k < 1000; k++) begin
            logic [N-1:0] ra, rbv;
            logic         rbo;
            ra  = N'($urandom);
            rbv = N'($urandom);
            rbo = 1'($urandom);
            for (int g = $urandom_range(0, 3); g > 0; g--) tick();
            model(ra, rbv, rbo, er, erb);
            do_op(ra, rbv, rbo, $urandom_range(0, 3), r, rb, lat);
            check("rnd_latency", lat, LAT);
            check("rnd_result", {23'd0, rb, r}, {23'd0, erb, er});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
